// File: rtl/im_port_arbiter_if.sv
// Bundle of the fetch, debug and instruction-memory signals around im_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface im_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_valid;
    logic [DATA_W-1:0] f_inst;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_inst;

    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_inst;

    modport slave (
        input  f_req, f_addr, d_req, d_addr, im_inst,
        output f_gnt, f_valid, f_inst, d_gnt, d_valid, d_inst, im_addr
    );

    modport master (
        output f_req, f_addr, d_req, d_addr, im_inst,
        input  f_gnt, f_valid, f_inst, d_gnt, d_valid, d_inst, im_addr
    );
endinterface

// File: rtl/im_port_arbiter.sv
// Shares the instruction-memory read port between fetch and debug, with a starvation bound for debug.
// Define IM_ARB_RR_EN to alternate owners on contention instead of fixed fetch priority.
//
// state      | meaning
// OWN_FETCH  | last granted read went to fetch
// OWN_DEBUG  | last granted read went to debug (reset value)
module im_port_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    im_port_arbiter_if.slave      bus
);
    localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DEBUG = 1'b1
    } owner_e;

    owner_e            last_owner;
    owner_e            last_owner_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_nxt;
    logic [ADDR_W-1:0] held_addr;
    logic              starve;
    logic              contend;
    logic              pick_debug;
    logic              f_win;
    logic              d_win;

    logic              f_valid_q;
    logic              d_valid_q;
    logic [DATA_W-1:0] f_inst_q;
    logic [DATA_W-1:0] d_inst_q;

    always_comb begin
        starve     = (wait_cnt == MAX_CNT);
        contend    = bus.f_req && bus.d_req;
`ifdef IM_ARB_RR_EN
        pick_debug = starve || (last_owner == OWN_FETCH);
`else
        pick_debug = starve;
`endif
        f_win = 1'b0;
        d_win = 1'b0;
        // Grants are suppressed while reset is held, whatever the requests do.
        if (!rst) begin
            if (contend) begin
                d_win = pick_debug;
                f_win = !pick_debug;
            end else begin
                f_win = bus.f_req;
                d_win = bus.d_req;
            end
        end

        last_owner_nxt = last_owner;
        if (f_win) begin
            last_owner_nxt = OWN_FETCH;
        end else if (d_win) begin
            last_owner_nxt = OWN_DEBUG;
        end

        wait_cnt_nxt = '0;
        if (bus.d_req && !d_win) begin
            wait_cnt_nxt = starve ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= OWN_DEBUG;
            wait_cnt   <= '0;
        end else begin
            last_owner <= last_owner_nxt;
            wait_cnt   <= wait_cnt_nxt;
        end
    end

    // Data path: capture the memory word for the winner, pulse its valid next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            f_inst_q  <= '0;
            d_inst_q  <= '0;
            held_addr <= '0;
        end else begin
            f_valid_q <= f_win;
            d_valid_q <= d_win;
            if (f_win) begin
                f_inst_q  <= bus.im_inst;
                held_addr <= bus.f_addr;
            end else if (d_win) begin
                d_inst_q  <= bus.im_inst;
                held_addr <= bus.d_addr;
            end
        end
    end

    // Idle cycles keep the last address so the memory is not re-addressed.
    assign bus.im_addr = f_win ? bus.f_addr : (d_win ? bus.d_addr : held_addr);
    assign bus.f_gnt   = f_win;
    assign bus.d_gnt   = d_win;
    assign bus.f_valid = f_valid_q;
    assign bus.d_valid = d_valid_q;
    assign bus.f_inst  = f_inst_q;
    assign bus.d_inst  = d_inst_q;
endmodule

// File: tb/tb_im_port_arbiter.sv
// Scoreboard bench for im_port_arbiter: directed test-plan cases plus randomized traffic
// against a behavioural arbitration model; a negedge monitor checks the returned words.
module tb_im_port_arbiter;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    im_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    im_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:31];
    assign bus.im_inst = mem[bus.im_addr];

    exp_t fq[$];
    exp_t dq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference model: 1 = fetch, 2 = debug
    int          m_last   = 2;
    int          m_streak = 0;
    logic [4:0]  m_held   = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit fe;
        bit de;
        fe = (fq.size() > 0) && (fq[0].cyc == cyc);
        de = (dq.size() > 0) && (dq[0].cyc == cyc);
        chk("f_valid", 32'(bus.f_valid), 32'(fe));
        chk("d_valid", 32'(bus.d_valid), 32'(de));
        if (fe) begin
            chk("f_inst", bus.f_inst, fq[0].data);
            void'(fq.pop_front());
        end
        if (de) begin
            chk("d_inst", bus.d_inst, dq[0].data);
            void'(dq.pop_front());
        end
    end

    task automatic cycle(input bit fr, input logic [4:0] fa, input bit dr, input logic [4:0] da,
                         output int dut_win);
        int         mw;
        logic [4:0] ea;
        @(posedge clk);
        #1;
        bus.f_req  = fr;
        bus.f_addr = fa;
        bus.d_req  = dr;
        bus.d_addr = da;
        mw = 0;
        if (fr && dr) begin
            if (m_streak >= MAX_WAIT) mw = 2;
`ifdef IM_ARB_RR_EN
            else mw = (m_last == 2) ? 1 : 2;
`else
            else mw = 1;
`endif
        end else if (fr) begin
            mw = 1;
        end else if (dr) begin
            mw = 2;
        end
        ea = (mw == 1) ? fa : ((mw == 2) ? da : m_held);
        #2;
        dut_win = bus.f_gnt ? 1 : (bus.d_gnt ? 2 : 0);
        chk("gnt_excl", 32'(bus.f_gnt & bus.d_gnt), 32'(0));
        chk("f_gnt", 32'(bus.f_gnt), 32'(mw == 1));
        chk("d_gnt", 32'(bus.d_gnt), 32'(mw == 2));
        chk("im_addr", 32'(bus.im_addr), 32'(ea));
        if (mw == 1) fq.push_back('{cyc + 1, mem[fa]});
        if (mw == 2) dq.push_back('{cyc + 1, mem[da]});
        if (dr && mw != 2) m_streak = (m_streak < MAX_WAIT) ? m_streak + 1 : MAX_WAIT;
        else m_streak = 0;
        if (mw != 0) begin
            m_last = mw;
            m_held = ea;
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.f_req = 1'b1;
        bus.d_req = 1'b1;
        fq.delete();
        dq.delete();
        m_last   = 2;
        m_streak = 0;
        m_held   = '0;
        #2;
        chk("rst_f_gnt", 32'(bus.f_gnt), 32'(0));
        chk("rst_d_gnt", 32'(bus.d_gnt), 32'(0));
        chk("rst_f_valid", 32'(bus.f_valid), 32'(0));
        chk("rst_d_valid", 32'(bus.d_valid), 32'(0));
        chk("rst_f_inst", bus.f_inst, 32'(0));
        chk("rst_d_inst", bus.d_inst, 32'(0));
        chk("rst_im_addr", 32'(bus.im_addr), 32'(0));
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        int         pat [6];
        bit         fp;
        bit         dp;
        logic [4:0] fa;
        logic [4:0] da;

        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[17] = 32'h00A00093;
        bus.f_req  = 1'b0;
        bus.f_addr = '0;
        bus.d_req  = 1'b0;
        bus.d_addr = '0;

        do_reset(2);

        // single fetch of word 17
        cycle(1'b1, 5'd17, 1'b0, 5'd0, w);
        cycle(1'b0, 5'd0, 1'b0, 5'd0, w);
        chk("f_inst_17", bus.f_inst, 32'h00A00093);

        // debug alone, address held afterwards
        cycle(1'b0, 5'd0, 1'b1, 5'd3, w);
        cycle(1'b0, 5'd0, 1'b0, 5'd0, w);
        cycle(1'b0, 5'd0, 1'b0, 5'd0, w);

        // starvation / round-robin pattern with both requests held
        do_reset(1);
`ifdef IM_ARB_RR_EN
        pat = '{1, 2, 1, 2, 1, 2};
`else
        pat = '{1, 1, 1, 1, 2, 1};
`endif
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 5'(i), 1'b1, 5'd20, w);
            chk("contend_pattern", 32'(w), 32'(pat[i]));
        end
        cycle(1'b0, 5'd0, 1'b0, 5'd0, w);
        cycle(1'b0, 5'd0, 1'b0, 5'd0, w);

        // reset in the cycle after a fetch grant drops the valid pulse
        cycle(1'b1, 5'd9, 1'b0, 5'd0, w);
        do_reset(1);

        // back-to-back fetch 0,1,2
        cycle(1'b1, 5'd0, 1'b0, 5'd0, w);
        cycle(1'b1, 5'd1, 1'b0, 5'd0, w);
        cycle(1'b1, 5'd2, 1'b0, 5'd0, w);
        cycle(1'b0, 5'd0, 1'b0, 5'd0, w);
        cycle(1'b0, 5'd0, 1'b0, 5'd0, w);

        // randomized traffic
        fp = 1'b0;
        dp = 1'b0;
        fa = '0;
        da = '0;
        for (int i = 0; i < 450; i++) begin
            if (!fp && $urandom_range(0, 2) != 0) begin
                fp = 1'b1;
                fa = 5'($urandom);
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1'b1;
                da = 5'($urandom);
            end else if (dp && $urandom_range(0, 15) == 0) begin
                dp = 1'b0;
            end
            cycle(fp, fa, dp, da, w);
            if (w == 1) begin
                fp = 1'($urandom_range(0, 1));
                fa = 5'($urandom);
            end else if (w == 2) begin
                dp = 1'($urandom_range(0, 1));
                da = 5'($urandom);
            end
            if (i % 150 == 149) begin
                do_reset(1);
                fp = 1'b0;
                dp = 1'b0;
            end
        end
        cycle(1'b0, 5'd0, 1'b0, 5'd0, w);
        cycle(1'b0, 5'd0, 1'b0, 5'd0, w);
        @(negedge clk);
        #1;
        chk("drain", 32'(fq.size() + dq.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
